// File: rtl/upa2_coef_store.sv
// Per-channel A2 / PK1 / PK2 store behind the a2 update stage: limits A2T to +/-0.75,
// applies the TR trigger, clears itself after reset. Optional limit counter: UPA2_LIM_COUNT_EN.
module upa2_coef_store #(
    parameter int CHANNELS = 32,
    parameter int CH_W     = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [15:0]     A2T,
    input  logic            PK0,
    input  logic            TR,
    input  logic            rd_req,
    input  logic [CH_W-1:0] rd_ch,
    output logic            rd_valid,
    output logic [15:0]     A2,
    output logic            PK1,
    output logic            PK2,
    output logic [15:0]     A2P,
    output logic            a2p_valid,
    output logic [15:0]     lim_count
);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CH_W:0]   CH_LIM     = (CH_W+1)'(CHANNELS);
    localparam logic [CH_W-1:0] SWEEP_LAST = CH_W'(CHANNELS - 1);

    function automatic logic [15:0] lim_a2(input logic [15:0] v);
        if ($signed(v) > $signed(16'sh3000)) begin
            return 16'h3000;
        end else if ($signed(v) < $signed(16'shD000)) begin
            return 16'hD000;
        end else begin
            return v;
        end
    endfunction

    state_t            r_state;
    state_t            w_state_nx;
    logic [CH_W-1:0]   r_sweep;
    logic [CH_W-1:0]   w_sweep_nx;
    logic              r_wr_ready;

    logic [15:0]       r_a2 [CHANNELS];
    logic [CHANNELS-1:0] r_pk1;
    logic [CHANNELS-1:0] r_pk2;

    logic              r_rd_valid;
    logic [15:0]       r_a2_out;
    logic              r_pk1_out;
    logic              r_pk2_out;
    logic [15:0]       r_a2p;
    logic              r_a2p_valid;

    logic [15:0]       w_a2p;
    logic [15:0]       w_a2_new;
    logic              w_wr_acc;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_wr_in_range;
    logic              w_rd_in_range;

    assign w_a2p         = lim_a2(A2T);
    assign w_a2_new      = TR ? 16'h0000 : w_a2p;
    assign w_wr_in_range = ({1'b0, wr_ch} < CH_LIM);
    assign w_rd_in_range = ({1'b0, rd_ch} < CH_LIM);
    assign w_wr_acc      = wr_valid && (r_state == RUN) && !reset;
    assign w_wr_en       = w_wr_acc && w_wr_in_range;
    assign w_rd_en       = rd_req && (r_state == RUN);

    // State register, sweep index and registered ready flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= INIT;
            r_sweep    <= {CH_W{1'b0}};
            r_wr_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sweep    <= w_sweep_nx;
            r_wr_ready <= (w_state_nx == RUN);
        end
    end

    // Next-state logic: INIT clears one channel per cycle, then RUN forever
    always_comb begin
        w_state_nx = r_state;
        w_sweep_nx = r_sweep;
        case (r_state)
            INIT: begin
                if (r_sweep == SWEEP_LAST) begin
                    w_state_nx = RUN;
                    w_sweep_nx = {CH_W{1'b0}};
                end else begin
                    w_sweep_nx = r_sweep + CH_W'(1);
                end
            end
            RUN: begin
                w_state_nx = RUN;
            end
            default: begin
                w_state_nx = INIT;
                w_sweep_nx = {CH_W{1'b0}};
            end
        endcase
    end

    // Channel storage: sweep clear during INIT, history shift on accepted writes
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_a2[r_sweep]  <= 16'h0000;
            r_pk1[r_sweep] <= 1'b0;
            r_pk2[r_sweep] <= 1'b0;
        end else if (w_wr_en) begin
            r_a2[wr_ch]  <= w_a2_new;
            r_pk2[wr_ch] <= r_pk1[wr_ch];
            r_pk1[wr_ch] <= PK0;
        end
    end

    // Registered read port; a same-cycle write to the same channel is forwarded
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_a2_out   <= 16'h0000;
            r_pk1_out  <= 1'b0;
            r_pk2_out  <= 1'b0;
        end else if (w_rd_en) begin
            r_rd_valid <= 1'b1;
            if (!w_rd_in_range) begin
                r_a2_out  <= 16'h0000;
                r_pk1_out <= 1'b0;
                r_pk2_out <= 1'b0;
            end else if (w_wr_en && (wr_ch == rd_ch)) begin
                r_a2_out  <= w_a2_new;
                r_pk1_out <= PK0;
                r_pk2_out <= r_pk1[wr_ch];
            end else begin
                r_a2_out  <= r_a2[rd_ch];
                r_pk1_out <= r_pk1[rd_ch];
                r_pk2_out <= r_pk2[rd_ch];
            end
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    // A2P monitor holds the limited value before TR is applied
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a2p       <= 16'h0000;
            r_a2p_valid <= 1'b0;
        end else begin
            r_a2p_valid <= w_wr_acc;
            if (w_wr_acc) begin
                r_a2p <= w_a2p;
            end
        end
    end

`ifdef UPA2_LIM_COUNT_EN
    logic [15:0] r_lim_count;
    logic        w_clamped;

    assign w_clamped = (w_a2p != A2T);

    // Saturating count of accepted writes whose A2T hit either bound
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lim_count <= 16'h0000;
        end else if (w_wr_acc && w_clamped && (r_lim_count != 16'hFFFF)) begin
            r_lim_count <= r_lim_count + 16'h0001;
        end
    end

    assign lim_count = r_lim_count;
`else
    assign lim_count = 16'h0000;
`endif

    assign wr_ready  = r_wr_ready;
    assign rd_valid  = r_rd_valid;
    assign A2        = r_a2_out;
    assign PK1       = r_pk1_out;
    assign PK2       = r_pk2_out;
    assign A2P       = r_a2p;
    assign a2p_valid = r_a2p_valid;

endmodule

// File: tb/tb_upa2_coef_store.sv
// Scoreboard bench for upa2_coef_store: directed plan items plus random traffic checked
// against an array-based reference model; a negedge monitor pops expected read/A2P results.
module tb_upa2_coef_store;

    localparam int CH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [4:0]  wr_ch = 5'd0;
    logic [15:0] A2T = 16'h0000;
    logic        PK0 = 1'b0;
    logic        TR = 1'b0;
    logic        rd_req = 1'b0;
    logic [4:0]  rd_ch = 5'd0;
    logic        rd_valid;
    logic [15:0] A2;
    logic        PK1;
    logic        PK2;
    logic [15:0] A2P;
    logic        a2p_valid;
    logic [15:0] lim_count;

    always #5 clk = ~clk;

    upa2_coef_store #(.CHANNELS(CH), .CH_W(5)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
        .A2T(A2T), .PK0(PK0), .TR(TR),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rd_valid),
        .A2(A2), .PK1(PK1), .PK2(PK2),
        .A2P(A2P), .a2p_valid(a2p_valid), .lim_count(lim_count)
    );

    typedef struct {int due; logic [15:0] a2; bit pk1; bit pk2;} rd_exp_t;
    typedef struct {int due; logic [15:0] v;} a2p_exp_t;

    rd_exp_t  rq[$];
    a2p_exp_t aq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] m_a2  [CH];
    bit          m_pk1 [CH];
    bit          m_pk2 [CH];
    bit          m_ready = 1'b0;
    int          m_cnt   = 0;
    int          m_lim   = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [15:0] ref_lim(input logic [15:0] x);
        int v;
        v = $signed(x);
        if (v > 12288) v = 12288;
        else if (v < -12288) v = -12288;
        return v[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model applies what the next rising edge will do
    task automatic drive(input bit rst, input bit wv, input int wch, input logic [15:0] a2t,
                         input bit pk0, input bit tr, input bit rqv, input int rch);
        logic [15:0] lv;
        @(posedge clk);
        #1;
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, m_ready});
        chk("lim_count", {16'd0, lim_count}, m_lim);
        reset = rst; wr_valid = wv; wr_ch = wch[4:0]; A2T = a2t;
        PK0 = pk0; TR = tr; rd_req = rqv; rd_ch = rch[4:0];
        if (wv && m_ready && !rst) begin
            lv = ref_lim(a2t);
            m_a2[wch]  = tr ? 16'h0000 : lv;
            m_pk2[wch] = m_pk1[wch];
            m_pk1[wch] = pk0;
            aq.push_back('{cyc + 1, lv});
`ifdef UPA2_LIM_COUNT_EN
            if (lv != a2t && m_lim < 65535) m_lim++;
`endif
        end
        if (rqv && m_ready && !rst)
            rq.push_back('{cyc + 1, m_a2[rch], m_pk1[rch], m_pk2[rch]});
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_lim   = 0;
            for (int i = 0; i < CH; i++) begin
                m_a2[i] = 16'h0000; m_pk1[i] = 1'b0; m_pk2[i] = 1'b0;
            end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == CH) m_ready = 1'b1;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Monitor: compares every presented read / A2P strobe with the scoreboard front
    always @(negedge clk) begin
        rd_exp_t  e;
        a2p_exp_t p;
        if (rd_valid === 1'b1) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected actual=rd_valid required=no_read (t=%0t)", $time);
            end else begin
                e = rq.pop_front();
                chk("rd_cycle", cyc, e.due);
                chk("rd_A2", {16'd0, A2}, {16'd0, e.a2});
                chk("rd_PK1", {31'd0, PK1}, {31'd0, e.pk1});
                chk("rd_PK2", {31'd0, PK2}, {31'd0, e.pk2});
            end
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            total++; bad++;
            $display("FAIL rd_missing actual=rd_valid_low required=read_due_%0d (t=%0t)", rq[0].due, $time);
            rq.delete(0);
        end
        if (a2p_valid === 1'b1) begin
            if (aq.size() == 0) begin
                total++; bad++;
                $display("FAIL a2p_unexpected actual=a2p_valid required=no_strobe (t=%0t)", $time);
            end else begin
                p = aq.pop_front();
                chk("a2p_cycle", cyc, p.due);
                chk("a2p_value", {16'd0, A2P}, {16'd0, p.v});
            end
        end else if (aq.size() > 0 && aq[0].due <= cyc) begin
            total++; bad++;
            $display("FAIL a2p_missing actual=a2p_valid_low required=strobe_due_%0d (t=%0t)", aq[0].due, $time);
            aq.delete(0);
        end
    end

    logic [15:0] lim_tab [5];

    initial begin
        lim_tab[0] = 16'h3001; lim_tab[1] = 16'h3000; lim_tab[2] = 16'hCFFF;
        lim_tab[3] = 16'hD000; lim_tab[4] = 16'h7FFF;

        // Reset held two cycles, then reset-state values
        drive(1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_a2p_valid", {31'd0, a2p_valid}, 32'd0);
        chk("rst_A2", {16'd0, A2}, 32'd0);
        chk("rst_PK1_PK2", {30'd0, PK1, PK2}, 32'd0);
        chk("rst_A2P", {16'd0, A2P}, 32'd0);
        chk("rst_lim_count", {16'd0, lim_count}, 32'd0);

        // INIT sweep: writes and reads offered here are dropped
        for (int i = 0; i < CH; i++)
            drive(1'b0, 1'b1, i, 16'h1111, 1'b1, 1'b0, 1'b1, i);
        drive(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 7);

        // Basic write/read and PK history shift
        drive(1'b0, 1'b1, 3, 16'h2000, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 3);
        drive(1'b0, 1'b1, 3, 16'h2000, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 3);

        // Limit bounds, each read back the next cycle
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 12, lim_tab[i], 1'b0, 1'b0, 1'b0, 0);
            drive(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 12);
        end
`ifdef UPA2_LIM_COUNT_EN
        chk("lim_count_plan", {16'd0, lim_count}, 32'd3);
`else
        chk("lim_count_plan", {16'd0, lim_count}, 32'd0);
`endif

        // Trigger forces A2 to zero, history still shifts, A2P shows unforced value
        drive(1'b0, 1'b1, 10, 16'h1234, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 10);

        // Same-cycle write and read of one channel
        drive(1'b0, 1'b1, 5, 16'h0100, 1'b1, 1'b0, 1'b1, 5);
        idle();

        // Reset mid-run cancels the concurrent read; writes in the sweep are dropped
        drive(1'b0, 1'b1, 0, 16'h0ABC, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        drive(1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < CH; i++)
            drive(1'b0, 1'b1, 0, 16'h0555, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 0);

        // Random traffic, biased toward a few channels to provoke collisions
        for (int n = 0; n < 600; n++) begin
            bit rs;
            int wc;
            int rc;
            rs = ($urandom_range(0, 249) == 0);
            wc = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, CH - 1);
            rc = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, CH - 1);
            drive(rs, 1'($urandom_range(0, 1)), wc, 16'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), rc);
        end

        repeat (3) idle();
        chk("rd_queue_drained", rq.size(), 32'd0);
        chk("a2p_queue_drained", aq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
